// File: rtl/fetch_stage_pkg.sv
// Shared CPU constants and IF/ID payload type used by the fetch stage.
package fetch_stage_pkg;

  localparam logic [5:0]  OP_J         = 6'b000010;
  localparam logic [31:0] NOP_VAL      = 32'h0000_0000;
  localparam logic [31:0] RESET_PC_DEF = 32'h0000_0000;

  typedef struct packed {
    logic [31:0] inst;
    logic [31:0] pc;
    logic [31:0] pc_plus4;
    logic        valid;
  } ifid_t;

  // J-type whose region-relative target is its own address.
  function automatic logic is_self_jump(input logic [31:0] inst, input logic [31:0] pc);
    return (inst[31:26] == OP_J) && ({pc[31:28], inst[25:0], 2'b00} == pc);
  endfunction

endpackage

// File: rtl/ifid_reg.sv
// IF/ID pipeline register: flush writes a bubble and keeps the PC fields,
// load captures a new payload, otherwise the contents hold.
module ifid_reg
  import fetch_stage_pkg::*;
#(
  parameter logic [31:0] NOP_INST = NOP_VAL
) (
  input  logic  clk,
  input  logic  rst_n,
  input  logic  load_i,
  input  logic  flush_i,
  input  ifid_t d_i,
  output ifid_t q_o
);

  ifid_t q_q, q_d;

  always_comb begin
    q_d = q_q;
    if (flush_i) begin
      q_d.inst  = NOP_INST;
      q_d.valid = 1'b0;
    end else if (load_i) begin
      q_d = d_i;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q_q.inst     <= NOP_INST;
      q_q.pc       <= '0;
      q_q.pc_plus4 <= '0;
      q_q.valid    <= 1'b0;
    end else begin
      q_q <= q_d;
    end
  end

  assign q_o = q_q;

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch: PC register, redirect/stall handling, jump-to-self halt
// detect, feeding the IF/ID register.
module fetch_stage
  import fetch_stage_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEF,
  parameter logic [31:0] NOP_INST = NOP_VAL
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        stall,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic [31:0] inst_addr,
  input  logic [31:0] inst_data,
  output logic [31:0] ifid_inst,
  output logic [31:0] ifid_pc,
  output logic [31:0] ifid_pc_plus4,
  output logic        ifid_valid,
  output logic        halted
);

  logic [31:0] pc_q, pc_d, pc_plus4;
  logic        halted_q, halted_d;
  logic        load, flush, halt_det;
  ifid_t       ifid_d, ifid_q;

  assign pc_plus4 = pc_q + 32'd4;
  assign load     = !redirect && !stall && !halted_q;
  // Once halted, every unstalled non-redirect cycle injects a bubble.
  assign flush    = redirect || (halted_q && !stall);
  assign halt_det = load && is_self_jump(inst_data, pc_q);

  always_comb begin
    pc_d = pc_plus4;
    if (redirect)                         pc_d = redirect_pc & ~32'h3;
    else if (halted_q || halt_det || stall) pc_d = pc_q;
  end

  assign halted_d = halted_q || halt_det;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q     <= RESET_PC;
      halted_q <= 1'b0;
    end else begin
      pc_q     <= pc_d;
      halted_q <= halted_d;
    end
  end

  assign ifid_d = '{inst: inst_data, pc: pc_q, pc_plus4: pc_plus4, valid: 1'b1};

  ifid_reg #(.NOP_INST(NOP_INST)) u_ifid (
    .clk    (clk),
    .rst_n  (rst_n),
    .load_i (load),
    .flush_i(flush),
    .d_i    (ifid_d),
    .q_o    (ifid_q)
  );

  assign inst_addr     = pc_q;
  assign ifid_inst     = ifid_q.inst;
  assign ifid_pc       = ifid_q.pc;
  assign ifid_pc_plus4 = ifid_q.pc_plus4;
  assign ifid_valid    = ifid_q.valid;
  assign halted        = halted_q;

endmodule

// File: tb/tb_fetch_stage.sv
// Directed vector bench for fetch_stage with a small combinational instruction memory.
module tb_fetch_stage;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        stall = 1'b0;
  logic        redirect = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic [31:0] inst_addr, inst_data;
  logic [31:0] ifid_inst, ifid_pc, ifid_pc_plus4;
  logic        ifid_valid, halted;

  int checks = 0;
  int failures = 0;

  logic [31:0] mem [0:63];

  always #5 clk = ~clk;

  assign inst_data = (inst_addr[31:8] == 24'd0) ? mem[inst_addr[7:2]] : 32'h0;

  fetch_stage dut (
    .clk(clk), .rst_n(rst_n), .stall(stall), .redirect(redirect),
    .redirect_pc(redirect_pc), .inst_addr(inst_addr), .inst_data(inst_data),
    .ifid_inst(ifid_inst), .ifid_pc(ifid_pc), .ifid_pc_plus4(ifid_pc_plus4),
    .ifid_valid(ifid_valid), .halted(halted)
  );

  typedef struct {
    logic        stall;
    logic        redirect;
    logic [31:0] rpc;
    logic [31:0] addr;
    logic [31:0] inst;
    logic [31:0] pc;
    logic [31:0] pc4;
    logic        valid;
    logic        halted;
  } vec_t;

  vec_t vecs [16];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic chk_all(input string tag, input logic [31:0] addr, input logic [31:0] inst,
                         input logic [31:0] pc, input logic [31:0] pc4,
                         input logic valid, input logic hlt);
    chk({tag, " inst_addr"}, inst_addr, addr);
    chk({tag, " ifid_inst"}, ifid_inst, inst);
    chk({tag, " ifid_pc"}, ifid_pc, pc);
    chk({tag, " ifid_pc_plus4"}, ifid_pc_plus4, pc4);
    chk({tag, " ifid_valid"}, {31'd0, ifid_valid}, {31'd0, valid});
    chk({tag, " halted"}, {31'd0, halted}, {31'd0, hlt});
  endtask

  initial begin
    for (int i = 0; i < 64; i++) mem[i] = 32'h1000_0000 | i;
    mem[0]  = 32'h2008_0002;
    mem[1]  = 32'h2009_0001;
    mem[22] = 32'h0800_0016;  // j 0x58 at 0x58

    //           stall red rpc           addr          inst          pc            pc4           v  h
    vecs[0]  = '{1'b0,1'b0,32'h0,        32'h4,        32'h2008_0002,32'h0,        32'h4,        1'b1,1'b0};
    vecs[1]  = '{1'b0,1'b0,32'h0,        32'h8,        32'h2009_0001,32'h4,        32'h8,        1'b1,1'b0};
    vecs[2]  = '{1'b1,1'b0,32'h0,        32'h8,        32'h2009_0001,32'h4,        32'h8,        1'b1,1'b0};
    vecs[3]  = '{1'b1,1'b0,32'h0,        32'h8,        32'h2009_0001,32'h4,        32'h8,        1'b1,1'b0};
    vecs[4]  = '{1'b0,1'b0,32'h0,        32'hC,        32'h1000_0002,32'h8,        32'hC,        1'b1,1'b0};
    vecs[5]  = '{1'b1,1'b1,32'h40,       32'h40,       32'h0,        32'h8,        32'hC,        1'b0,1'b0};
    vecs[6]  = '{1'b0,1'b0,32'h0,        32'h44,       32'h1000_0010,32'h40,       32'h44,       1'b1,1'b0};
    vecs[7]  = '{1'b0,1'b1,32'hFFFF_FFFC,32'hFFFF_FFFC,32'h0,        32'h40,       32'h44,       1'b0,1'b0};
    vecs[8]  = '{1'b0,1'b0,32'h0,        32'h0,        32'h0,        32'hFFFF_FFFC,32'h0,        1'b1,1'b0};
    vecs[9]  = '{1'b0,1'b1,32'h57,       32'h54,       32'h0,        32'hFFFF_FFFC,32'h0,        1'b0,1'b0};
    vecs[10] = '{1'b0,1'b0,32'h0,        32'h58,       32'h1000_0015,32'h54,       32'h58,       1'b1,1'b0};
    vecs[11] = '{1'b0,1'b0,32'h0,        32'h58,       32'h0800_0016,32'h58,       32'h5C,       1'b1,1'b1};
    vecs[12] = '{1'b0,1'b0,32'h0,        32'h58,       32'h0,        32'h58,       32'h5C,       1'b0,1'b1};
    vecs[13] = '{1'b1,1'b0,32'h0,        32'h58,       32'h0,        32'h58,       32'h5C,       1'b0,1'b1};
    vecs[14] = '{1'b0,1'b1,32'h40,       32'h40,       32'h0,        32'h58,       32'h5C,       1'b0,1'b1};
    vecs[15] = '{1'b0,1'b0,32'h0,        32'h40,       32'h0,        32'h58,       32'h5C,       1'b0,1'b1};

    #2;
    chk_all("reset", 32'h0, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 16; i++) begin
      stall       = vecs[i].stall;
      redirect    = vecs[i].redirect;
      redirect_pc = vecs[i].rpc;
      @(posedge clk);
      #1;
      chk_all($sformatf("vec%0d", i), vecs[i].addr, vecs[i].inst, vecs[i].pc,
              vecs[i].pc4, vecs[i].valid, vecs[i].halted);
    end

    // Asynchronous reset mid-stall while halted, with a redirect pending.
    stall = 1'b1;
    redirect = 1'b1;
    redirect_pc = 32'h80;
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    chk_all("async_rst", 32'h0, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0);
    @(negedge clk);
    stall = 1'b0;
    redirect = 1'b0;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk_all("post_rst", 32'h4, 32'h2008_0002, 32'h0, 32'h4, 1'b1, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
